// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. The granted operands/opcode are latched and drive the ALU from
// registers. After ALU_LAT cycles the result and zero flag are captured and
// returned to the owning requester over its response channel.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0 request channel
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [OPW-1:0]   req0_op,
  // requester 1 request channel
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [OPW-1:0]   req1_op,
  // requester 0 response channel
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_res,
  output logic             rsp0_zero,
  // requester 1 response channel
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_res,
  output logic             rsp1_zero,
  // shared ALU
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero
);

  // Latency counter only needs to reach ALU_LAT-1.
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [WIDTH-1:0] r_A;
  logic [WIDTH-1:0] r_B;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic [CW-1:0]    r_lat_cnt;

  logic             w_grant_valid;
  logic             w_grant;
  logic             w_rsp_ready;

  // Round-robin arbitration while IDLE; on a tie the requester that was not
  // served last wins. Gated by rst so no grant leaks out during reset.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_grant_valid = 1'b0;
    w_grant       = 1'b0;
    if (r_state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        w_grant_valid = 1'b1;
        w_grant       = ~r_last_grant;
      end else if (req0_valid) begin
        w_grant_valid = 1'b1;
        w_grant       = 1'b0;
      end else if (req1_valid) begin
        w_grant_valid = 1'b1;
        w_grant       = 1'b1;
      end
    end
  end

  // A ready is only ever raised for the single granted requester.
  assign req0_ready = w_grant_valid & ~w_grant;
  assign req1_ready = w_grant_valid &  w_grant;

  // Only the owner's rsp_ready can complete the response.
  assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

  // Response channels: data on both, qualified only by the owner's valid.
  assign rsp0_valid = (r_state == RESP) & ~r_owner;
  assign rsp1_valid = (r_state == RESP) &  r_owner;
  assign rsp0_res   = r_res;
  assign rsp1_res   = r_res;
  assign rsp0_zero  = r_zero;
  assign rsp1_zero  = r_zero;

  // ALU is driven from the latched registers; they hold outside EXEC too.
  assign alu_A  = r_A;
  assign alu_B  = r_B;
  assign alu_op = r_op;

  // Control FSM plus operand/result capture.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;  // requester 0 wins the first tie
      r_owner      <= 1'b0;
      r_A          <= '0;
      r_B          <= '0;
      r_op         <= '0;
      r_res        <= '0;
      r_zero       <= 1'b0;
      r_lat_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_A          <= w_grant ? req1_A  : req0_A;
            r_B          <= w_grant ? req1_B  : req0_B;
            r_op         <= w_grant ? req1_op : req0_op;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_lat_cnt    <= '0;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_lat_cnt <= r_lat_cnt + 1'b1;
          if (r_lat_cnt == LAT_LAST) begin
            r_res   <= alu_res;
            r_zero  <= alu_zero;
            r_state <= RESP;
          end
        end
        RESP: begin
          if (w_rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level reference model (cycle-numbered grant/response timing).
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ALU_LAT=1 instance signals
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_res, rsp1_res;
  logic [31:0] alu_A, alu_B, alu_res;
  logic [3:0]  alu_op;
  logic        alu_zero;

  // ALU_LAT=3 instance signals
  logic        q_req0_valid, q_req0_ready, q_req1_valid, q_req1_ready;
  logic [31:0] q_req0_A, q_req0_B, q_req1_A, q_req1_B;
  logic [3:0]  q_req0_op, q_req1_op;
  logic        q_rsp0_valid, q_rsp0_ready, q_rsp0_zero, q_rsp1_valid, q_rsp1_ready, q_rsp1_zero;
  logic [31:0] q_rsp0_res, q_rsp1_res;
  logic [31:0] q_alu_A, q_alu_B, q_alu_res;
  logic [3:0]  q_alu_op;
  logic        q_alu_zero;

  // ALU stub: 0000 add, 0001 sub, 1001 and.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1001: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_res    = alu_f(alu_op, alu_A, alu_B);
  assign alu_zero   = (alu_res == 32'h0);
  assign q_alu_res  = alu_f(q_alu_op, q_alu_A, q_alu_B);
  assign q_alu_zero = (q_alu_res == 32'h0);

  alu_arbiter #(.WIDTH(32), .OPW(4), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_zero(rsp1_zero),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_res(alu_res), .alu_zero(alu_zero)
  );

  alu_arbiter #(.WIDTH(32), .OPW(4), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(q_req0_valid), .req0_ready(q_req0_ready), .req0_A(q_req0_A), .req0_B(q_req0_B), .req0_op(q_req0_op),
    .req1_valid(q_req1_valid), .req1_ready(q_req1_ready), .req1_A(q_req1_A), .req1_B(q_req1_B), .req1_op(q_req1_op),
    .rsp0_valid(q_rsp0_valid), .rsp0_ready(q_rsp0_ready), .rsp0_res(q_rsp0_res), .rsp0_zero(q_rsp0_zero),
    .rsp1_valid(q_rsp1_valid), .rsp1_ready(q_rsp1_ready), .rsp1_res(q_rsp1_res), .rsp1_zero(q_rsp1_zero),
    .alu_A(q_alu_A), .alu_B(q_alu_B), .alu_op(q_alu_op), .alu_res(q_alu_res), .alu_zero(q_alu_zero)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: one transaction in flight; response due LAT+1 cycles
  // after the accept cycle, block free again the cycle after the handshake.
  int          t = 0;
  bit          m_active = 1'b0;
  bit          m_owner  = 1'b0;
  bit          m_last   = 1'b1;
  int          m_rsp_from = 0;
  logic [31:0] m_res = '0;
  bit          m_zero = 1'b0;
  int          m_grant = -1;
  int          grant_log[$];
  logic [31:0] rsp_log[$];

  task automatic model_reset();
    m_active = 1'b0;
    m_last   = 1'b1;
  endtask

  // Settle combinational outputs, predict this cycle and compare.
  task automatic sample();
    bit ev0, ev1;
    #1;
    m_grant = -1;
    if (!m_active) begin
      if (req0_valid && req1_valid) m_grant = m_last ? 0 : 1;
      else if (req0_valid)          m_grant = 0;
      else if (req1_valid)          m_grant = 1;
    end
    check("req0_ready", req0_ready, m_grant == 0);
    check("req1_ready", req1_ready, m_grant == 1);
    ev0 = m_active && (t >= m_rsp_from) && !m_owner;
    ev1 = m_active && (t >= m_rsp_from) &&  m_owner;
    check("rsp0_valid", rsp0_valid, ev0);
    check("rsp1_valid", rsp1_valid, ev1);
    if (ev0) begin
      check("rsp0_res", rsp0_res, m_res);
      check("rsp0_zero", rsp0_zero, m_zero);
    end
    if (ev1) begin
      check("rsp1_res", rsp1_res, m_res);
      check("rsp1_zero", rsp1_zero, m_zero);
    end
  endtask

  // Apply this cycle's handshakes to the model, then advance one edge.
  task automatic commit();
    if (m_grant == 0) begin
      m_active = 1'b1; m_owner = 1'b0; m_last = 1'b0; m_rsp_from = t + LAT + 1;
      m_res = alu_f(req0_op, req0_A, req0_B); m_zero = (m_res == 32'h0);
    end else if (m_grant == 1) begin
      m_active = 1'b1; m_owner = 1'b1; m_last = 1'b1; m_rsp_from = t + LAT + 1;
      m_res = alu_f(req1_op, req1_A, req1_B); m_zero = (m_res == 32'h0);
    end else if (m_active && t >= m_rsp_from && (m_owner ? rsp1_ready : rsp0_ready)) begin
      rsp_log.push_back(m_owner ? rsp1_res : rsp0_res);
      m_active = 1'b0;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  // Run n cycles; a granted request is withdrawn unless hold is set.
  task automatic run(input int n, input bit hold);
    for (int i = 0; i < n; i++) begin
      sample();
      if (m_grant >= 0) grant_log.push_back(m_grant);
      commit();
      if (!hold && m_grant == 0) req0_valid = 1'b0;
      if (!hold && m_grant == 1) req1_valid = 1'b0;
    end
  endtask

  task automatic rand_req(output logic [31:0] a, output logic [31:0] b, output logic [3:0] op);
    int sel;
    a   = $urandom;
    b   = ($urandom_range(3, 0) == 0) ? a : $urandom;
    sel = $urandom_range(2, 0);
    op  = (sel == 0) ? 4'b0000 : (sel == 1) ? 4'b0001 : 4'b1001;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req0_ready"}, req0_ready, 1'b0);
    check({tag, "_req1_ready"}, req1_ready, 1'b0);
    check({tag, "_rsp0_valid"}, rsp0_valid, 1'b0);
    check({tag, "_rsp1_valid"}, rsp1_valid, 1'b0);
    check({tag, "_alu_A"}, alu_A, 32'h0);
    check({tag, "_alu_B"}, alu_B, 32'h0);
    check({tag, "_alu_op"}, alu_op, 4'h0);
    check({tag, "_rsp0_res"}, rsp0_res, 32'h0);
    check({tag, "_rsp0_zero"}, rsp0_zero, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_op = '0;
    req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    q_req0_valid = 1'b0; q_req0_A = '0; q_req0_B = '0; q_req0_op = '0;
    q_req1_valid = 1'b0; q_req1_A = '0; q_req1_B = '0; q_req1_op = '0;
    q_rsp0_ready = 1'b0; q_rsp1_ready = 1'b0;

    // Reset state; a valid request during reset must not be granted.
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_q_req0_ready", q_req0_ready, 1'b0);
    check("reset_q_alu_op", q_alu_op, 4'h0);
    req0_valid = 1'b0;
    rst = 1'b0;
    model_reset();

    // Tie after reset: requester 0 first, then requester 1.
    req0_A = 32'h7FFFFFFF; req0_B = 32'h00000001; req0_op = 4'b0000; req0_valid = 1'b1;
    req1_A = 32'h80000000; req1_B = 32'h00000001; req1_op = 4'b0001; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    grant_log.delete(); rsp_log.delete();
    run(6, 1'b0);
    check("tie_ngrants", grant_log.size(), 2);
    check("tie_first", grant_log[0], 0);
    check("tie_second", grant_log[1], 1);
    check("tie_res0", rsp_log[0], 32'h80000000);
    check("tie_res1", rsp_log[1], 32'h7FFFFFFF);

    // Repeated ties with both valid held for four operations.
    req0_valid = 1'b1; req1_valid = 1'b1;
    grant_log.delete();
    run(12, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), grant_log[i], i % 2);

    // Single requester 0 add.
    req0_A = 32'hA5A5A5A5; req0_B = 32'h5A5A5A5A; req0_op = 4'b0000; req0_valid = 1'b1;
    rsp0_ready = 1'b0;
    run(1, 1'b0);
    check("single_alu_op", alu_op, 4'b0000);
    check("single_alu_A", alu_A, 32'hA5A5A5A5);
    check("single_alu_B", alu_B, 32'h5A5A5A5A);
    run(1, 1'b0);
    check("single_rsp0_valid", rsp0_valid, 1'b1);
    check("single_rsp1_valid", rsp1_valid, 1'b0);
    check("single_res", rsp0_res, 32'hFFFFFFFF);
    check("single_zero", rsp0_zero, 1'b0);
    rsp0_ready = 1'b1;
    run(1, 1'b0);
    check("single_done", rsp0_valid, 1'b0);

    // Zero flag with response backpressure; requester 0 waits meanwhile.
    req1_A = 32'h12345678; req1_B = 32'h12345678; req1_op = 4'b0001; req1_valid = 1'b1;
    rsp1_ready = 1'b0;
    run(1, 1'b0);
    req0_A = 32'h00000003; req0_B = 32'h00000004; req0_op = 4'b0000; req0_valid = 1'b1;
    run(1, 1'b0);
    grant_log.delete();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp1_valid", rsp1_valid, 1'b1);
      check("bp_rsp1_res", rsp1_res, 32'h0);
      check("bp_rsp1_zero", rsp1_zero, 1'b1);
      run(1, 1'b0);
    end
    rsp1_ready = 1'b1;
    run(1, 1'b0);
    rsp1_ready = 1'b0;
    check("bp_no_early_grant", grant_log.size(), 0);
    run(1, 1'b0);
    check("bp_grant_after", grant_log.size(), 1);
    run(2, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid) begin
        if ($urandom_range(1, 0) == 1) begin rand_req(req0_A, req0_B, req0_op); req0_valid = 1'b1; end
      end else if ($urandom_range(7, 0) == 0) req0_valid = 1'b0;
      if (!req1_valid) begin
        if ($urandom_range(1, 0) == 1) begin rand_req(req1_A, req1_B, req1_op); req1_valid = 1'b1; end
      end else if ($urandom_range(7, 0) == 0) req1_valid = 1'b0;
      rsp0_ready = 1'($urandom_range(1, 0));
      rsp1_ready = 1'($urandom_range(1, 0));
      run(1, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    run(4, 1'b0);

    // ALU_LAT=3 instance: EXEC holds inputs for exactly three cycles.
    q_req0_A = 32'hFFFFFFFF; q_req0_B = 32'h80000000; q_req0_op = 4'b1001; q_req0_valid = 1'b1;
    #1;
    check("lat3_ready", q_req0_ready, 1'b1);
    @(posedge clk); #1;
    q_req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("lat3_alu_A", q_alu_A, 32'hFFFFFFFF);
      check("lat3_alu_B", q_alu_B, 32'h80000000);
      check("lat3_alu_op", q_alu_op, 4'b1001);
      check("lat3_no_rsp", q_rsp0_valid, 1'b0);
      @(posedge clk); #1;
    end
    check("lat3_rsp_valid", q_rsp0_valid, 1'b1);
    check("lat3_res", q_rsp0_res, 32'h80000000);
    check("lat3_zero", q_rsp0_zero, 1'b0);
    check("lat3_rsp1_valid", q_rsp1_valid, 1'b0);
    q_rsp0_ready = 1'b1;
    @(posedge clk); #1;
    q_rsp0_ready = 1'b0;
    check("lat3_done", q_rsp0_valid, 1'b0);

    // Reset asserted in EXEC: outputs clear at once, no response follows.
    req0_A = 32'h00000010; req0_B = 32'h00000020; req0_op = 4'b0000; req0_valid = 1'b1;
    rsp0_ready = 1'b1;
    run(1, 1'b0);
    check("pre_rst_alu_A", alu_A, 32'h00000010);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run(4, 1'b0);
    rsp_log.delete();
    req0_A = 32'h00000005; req0_B = 32'h00000002; req0_op = 4'b0001; req0_valid = 1'b1;
    run(3, 1'b0);
    check("post_rst_nrsp", rsp_log.size(), 1);
    check("post_rst_res", rsp_log[0], 32'h00000003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
